// File: rtl/alu_pkg.sv
// Shared definitions for the alu_arbiter block: opcode encoding, FSM state encoding and default datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_MUL = 3'b001,
    OP_SUB = 3'b010,
    OP_DIV = 3'b011,
    OP_SHR = 3'b100,
    OP_SHL = 3'b101,
    OP_NOR = 3'b110,
    OP_XOR = 3'b111
  } alu_op_e;

  typedef logic [1:0] alu_state_t;

  localparam alu_state_t ST_IDLE = 2'd0;
  localparam alu_state_t ST_EXEC = 2'd1;
  localparam alu_state_t ST_RESP = 2'd2;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle for alu_arbiter: two requesters and one result consumer.
// resp_err exists only when ALU_ARBITER_DIV0_ERR_EN is defined.
interface alu_arbiter_if #(
  parameter int WIDTH = alu_pkg::ALU_WIDTH
);

  logic             req0_valid;
  logic             req0_ready;
  logic [2:0]       req0_opcode;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [2:0]       req1_opcode;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [WIDTH-1:0] resp_result;
`ifdef ALU_ARBITER_DIV0_ERR_EN
  logic             resp_err;
`endif

  modport master (
    output req0_valid, req0_opcode, req0_a, req0_b,
    output req1_valid, req1_opcode, req1_a, req1_b,
    output resp_ready,
    input  req0_ready, req1_ready,
`ifdef ALU_ARBITER_DIV0_ERR_EN
    input  resp_err,
`endif
    input  resp_valid, resp_id, resp_result
  );

  modport slave (
    input  req0_valid, req0_opcode, req0_a, req0_b,
    input  req1_valid, req1_opcode, req1_a, req1_b,
    input  resp_ready,
    output req0_ready, req1_ready,
`ifdef ALU_ARBITER_DIV0_ERR_EN
    output resp_err,
`endif
    output resp_valid, resp_id, resp_result
  );

endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU: decodes a 3-bit opcode over two unsigned WIDTH-bit operands.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [2:0]       i_opcode,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result
);

  typedef logic [WIDTH-1:0] word_t;

  localparam word_t WIDTH_W = word_t'(WIDTH);
  localparam word_t ZERO_W  = {WIDTH{1'b0}};
  localparam word_t ONES_W  = {WIDTH{1'b1}};

  // Opcode decode; shift amounts compare the full B value so large shifts saturate to zero.
  always_comb begin
    o_result = ZERO_W;
    case (i_opcode)
      OP_ADD: o_result = i_a + i_b;
      OP_MUL: o_result = i_a * i_b;
      OP_SUB: o_result = i_a - i_b;
      OP_DIV: begin
        if (i_b == ZERO_W) begin
          o_result = ONES_W;
        end else begin
          o_result = i_a / i_b;
        end
      end
      OP_SHR: begin
        if (i_b >= WIDTH_W) begin
          o_result = ZERO_W;
        end else begin
          o_result = i_a >> i_b;
        end
      end
      OP_SHL: begin
        if (i_b >= WIDTH_W) begin
          o_result = ZERO_W;
        end else begin
          o_result = i_a << i_b;
        end
      end
      OP_NOR:  o_result = ~(i_a | i_b);
      OP_XOR:  o_result = i_a ^ i_b;
      default: o_result = ZERO_W;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared ALU with a registered, back-pressured response.
// Optional feature macro: ALU_ARBITER_DIV0_ERR_EN adds resp_err (DIV by zero flag).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  logic [1:0]       r_state;
  logic             r_last;
  logic             r_id;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_resp_valid;
  logic             r_resp_id;
  logic [WIDTH-1:0] r_resp_result;

  logic             w_idle;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_hs;
  logic [WIDTH-1:0] w_alu_result;

`ifdef ALU_ARBITER_DIV0_ERR_EN
  logic r_resp_err;
  logic w_div0;
`endif

  // Grant generation: r_last high means requester 1 was served last, so requester 0 wins a tie.
  always_comb begin
    w_idle   = rst_n && (r_state == ST_IDLE);
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (w_idle) begin
      if (bus.req0_valid && bus.req1_valid) begin
        w_grant0 = r_last;
        w_grant1 = ~r_last;
      end else begin
        w_grant0 = bus.req0_valid;
        w_grant1 = bus.req1_valid;
      end
    end else begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
    end
    w_hs = w_grant0 | w_grant1;
  end

  // Capture the winning request and advance the round-robin pointer on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op   <= 3'b000;
      r_a    <= {WIDTH{1'b0}};
      r_b    <= {WIDTH{1'b0}};
      r_id   <= 1'b0;
      r_last <= 1'b1;
    end else if (w_hs) begin
      r_id   <= w_grant1;
      r_last <= w_grant1;
      if (w_grant1) begin
        r_op <= bus.req1_opcode;
        r_a  <= bus.req1_a;
        r_b  <= bus.req1_b;
      end else begin
        r_op <= bus.req0_opcode;
        r_a  <= bus.req0_a;
        r_b  <= bus.req0_b;
      end
    end
  end

  alu_core #(
    .WIDTH(WIDTH)
  ) u_alu_core (
    .i_opcode(r_op),
    .i_a     (r_a),
    .i_b     (r_b),
    .o_result(w_alu_result)
  );

`ifdef ALU_ARBITER_DIV0_ERR_EN
  assign w_div0 = (r_op == OP_DIV) && (r_b == {WIDTH{1'b0}});
`endif

  // Sequencer and response register: result is captured at the end of EXEC and held until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_resp_valid  <= 1'b0;
      r_resp_id     <= 1'b0;
      r_resp_result <= {WIDTH{1'b0}};
`ifdef ALU_ARBITER_DIV0_ERR_EN
      r_resp_err    <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_state       <= ST_RESP;
          r_resp_valid  <= 1'b1;
          r_resp_id     <= r_id;
          r_resp_result <= w_alu_result;
`ifdef ALU_ARBITER_DIV0_ERR_EN
          r_resp_err    <= w_div0;
`endif
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            r_state      <= ST_IDLE;
            r_resp_valid <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_resp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req0_ready  = w_grant0;
  assign bus.req1_ready  = w_grant1;
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_id     = r_resp_id;
  assign bus.resp_result = r_resp_result;
`ifdef ALU_ARBITER_DIV0_ERR_EN
  assign bus.resp_err    = r_resp_err;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed requests push hand-computed results at handshake,
// a negedge monitor pops and compares whenever a response is presented and accepted.
`timescale 1ns/1ps
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        err;
    int          t_hs;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  exp_t exp0;
  exp_t exp1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter_if #(.WIDTH(W)) bus ();

  alu_arbiter #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Handshake watcher: the accepted request's expected response enters the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.req0_ready || bus.req1_ready)
        check("single_ready", {63'd0, bus.req0_ready & bus.req1_ready}, 64'd0);
      if (bus.req0_ready && bus.req0_valid) begin
        e = exp0; e.t_hs = cyc; sb.push_back(e);
      end
      if (bus.req1_ready && bus.req1_valid) begin
        e = exp1; e.t_hs = cyc; sb.push_back(e);
      end
    end
  end

  // Response monitor: latency on first presentation, stability while stalled, content on accept.
  initial begin
    logic        seen;
    logic        hold_id;
    logic [31:0] hold_res;
    exp_t        e;
    seen = 1'b0; hold_id = 1'b0; hold_res = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 1'b0;
      end else if (bus.resp_valid) begin
        if (!seen) begin
          seen = 1'b1; hold_id = bus.resp_id; hold_res = bus.resp_result;
          if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL resp_unexpected: got id=%0d result=%h, required no response", bus.resp_id, bus.resp_result);
          end else begin
            check("resp_latency", 64'(cyc - sb[0].t_hs), 64'd2);
          end
        end else begin
          check("resp_stable", {31'd0, bus.resp_id, bus.resp_result}, {31'd0, hold_id, hold_res});
        end
        if (bus.resp_ready) begin
          seen = 1'b0;
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("resp_id", {63'd0, bus.resp_id}, {63'd0, e.id});
            check("resp_result", {32'd0, bus.resp_result}, {32'd0, e.res});
`ifdef ALU_ARBITER_DIV0_ERR_EN
            check("resp_err", {63'd0, bus.resp_err}, {63'd0, e.err});
`endif
          end
        end
      end
    end
  end

  task automatic post(input int r, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input logic err);
    if (r == 0) begin
      exp0 = '{1'b0, res, err, 0};
      bus.req0_opcode = op; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
    end else begin
      exp1 = '{1'b1, res, err, 0};
      bus.req1_opcode = op; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
    end
  endtask

  task automatic wait_accept(input int r, output int waited);
    waited = 0;
    forever begin
      @(negedge clk);
      if ((r == 0 && bus.req0_ready) || (r == 1 && bus.req1_ready)) break;
      waited++;
      if (waited > 30) begin
        n_checks++; n_fail++;
        $display("FAIL accept_timeout_req%0d: no ready after %0d cycles, required a grant", r, waited);
        break;
      end
    end
    @(posedge clk); #1;
    if (r == 0) bus.req0_valid = 1'b0;
    else        bus.req1_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input int r, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input logic err);
    int w;
    post(r, op, a, b, res, err);
    wait_accept(r, w);
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded time limit, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    bus.req0_valid = 1'b0; bus.req0_opcode = 3'b000; bus.req0_a = 32'd0; bus.req0_b = 32'd0;
    bus.req1_valid = 1'b0; bus.req1_opcode = 3'b000; bus.req1_a = 32'd0; bus.req1_b = 32'd0;
    bus.resp_ready = 1'b1;
    #1 rst_n = 1'b0;

    // Reset state, with both requesters already waiting.
    post(0, OP_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0);
    post(1, OP_XOR, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    check("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    check("rst_resp_id", {63'd0, bus.resp_id}, 64'd0);
    check("rst_resp_result", {32'd0, bus.resp_result}, 64'd0);
    check("rst_ready0", {63'd0, bus.req0_ready}, 64'd0);
    check("rst_ready1", {63'd0, bus.req1_ready}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Tie after reset goes to requester 0, then requester 1.
    wait_accept(0, w);
    check("tie_req0_first", 64'(w), 64'd0);
    wait_accept(1, w);
    drain();

    // Single ADD: ready in the first IDLE cycle, response two cycles later.
    post(0, OP_ADD, 32'd7, 32'd5, 32'd12, 1'b0);
    wait_accept(0, w);
    check("add_ready_at_T", 64'(w), 64'd0);
    drain();

    run(0, OP_DIV, 32'd100, 32'd0, 32'hFFFF_FFFF, 1'b1);
    run(1, OP_DIV, 32'd100, 32'd7, 32'd14, 1'b0);
    run(0, OP_SHL, 32'd1, 32'd31, 32'h8000_0000, 1'b0);
    run(1, OP_SHR, 32'hFFFF_FFFF, 32'd32, 32'd0, 1'b0);
    run(0, OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0);
    run(1, OP_MUL, 32'h0001_2345, 32'h0000_0010, 32'h0012_3450, 1'b0);
    run(0, OP_SHR, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0);
    run(1, OP_SHL, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run(0, OP_ADD, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0);

    // Back-pressure: response held, requester 1 kept waiting until acceptance.
    bus.resp_ready = 1'b0;
    post(0, OP_NOR, 32'h0F0F_0000, 32'h00F0_F000, 32'hF000_0FFF, 1'b0);
    wait_accept(0, w);
    post(1, OP_SUB, 32'd10, 32'd3, 32'd7, 1'b0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("stall_req1_ready", {63'd0, bus.req1_ready}, 64'd0);
    end
    check("stall_resp_valid", {63'd0, bus.resp_valid}, 64'd1);
    @(posedge clk); #1 bus.resp_ready = 1'b1;
    wait_accept(1, w);
    drain();

    // Reset during EXEC: the in-flight MUL is dropped and the pointer returns to favour requester 0.
    post(0, OP_MUL, 32'd3, 32'd5, 32'd15, 1'b0);
    wait_accept(0, w);
    rst_n = 1'b0;
    sb.delete();
    post(0, OP_ADD, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0);
    post(1, OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0);
    #1 check("midrst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("midrst_ready0", {63'd0, bus.req0_ready}, 64'd0);
      check("midrst_ready1", {63'd0, bus.req1_ready}, 64'd0);
      check("midrst_valid", {63'd0, bus.resp_valid}, 64'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    wait_accept(0, w);
    check("post_rst_tie_req0", 64'(w), 64'd0);
    wait_accept(1, w);
    drain();
    repeat (4) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req0_valid  input  1  requester 0 has an operation pending.
REQ-005 SHALL have port: req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 SHALL have port: req0_opcode  input  3  requester 0 operation code.
REQ-007 SHALL have ports: req0_a, req0_b  input  WIDTH  requester 0 operands.
REQ-008 SHALL have ports: req1_valid, req1_ready, req1_opcode, req1_a, req1_b, same directions, widths and meanings for requester 1.
REQ-009 SHALL have port: resp_valid  output  1  result available.
REQ-010 SHALL have port: resp_ready  input  1  consumer accepts result.
REQ-011 SHALL have port: resp_id  output  1  requester index owning the result.
REQ-012 SHALL have port: resp_result  output  WIDTH  registered operation result.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, RESP; IDLE->EXEC on request handshake, EXEC->RESP unconditionally after one cycle, RESP->IDLE on resp_valid & resp_ready.
REQ-014 SHALL assert at most one reqN_ready, only in IDLE, combinationally to the granted requester while its valid is high.
REQ-015 SHALL arbitrate round-robin: single valid wins; both valid -> requester not granted last wins; last-grant pointer updates only on handshake.
REQ-016 SHALL latch opcode, operands and winner index on handshake (edge T), evaluate in EXEC (cycle T+1), register result at end of T+1, assert resp_valid from cycle T+2.
REQ-017 SHALL hold resp_valid, resp_id, resp_result stable until resp_ready; minimum issue interval 3 cycles.
REQ-018 SHALL decode opcodes: 000 ADD, 001 MUL (low WIDTH bits), 010 SUB (wrap modulo 2^WIDTH), 011 DIV (unsigned quotient), 100 SHR logical, 101 SHL, 110 NOR, 111 XOR.
REQ-019 SHALL yield 0 for shifts where B >= WIDTH (full B value used, no truncation).
REQ-020 SHALL yield all-ones for DIV with B == 0.
REQ-021 SHALL ignore reqN_valid outside IDLE; requesters hold valid and operands stable until ready.

Reset
REQ-022 SHALL on rst_n low immediately force state IDLE, resp_valid 0, resp_id 0, resp_result 0, last-grant pointer 1 (requester 0 wins first tie).
REQ-023 SHALL discard any in-flight operation or pending response on reset mid-operation; no response emitted after release.
REQ-024 SHALL drive req0_ready, req1_ready 0 while rst_n is low.

Configuration
REQ-025 SHALL, with ALU_ARBITER_DIV0_ERR_EN defined, add output resp_err (1 bit) registered with resp_result, 1 iff the response is DIV with B == 0, reset 0, held stable with resp_valid.
REQ-026 SHALL, without ALU_ARBITER_DIV0_ERR_EN, omit resp_err; all other behaviour identical.

Structure
REQ-027 SHALL place opcode constants/enum (ADD..XOR), FSM state typedef and default WIDTH in shared package alu_pkg.
REQ-028 SHALL instantiate one combinational sub-module alu_core (opcode, a, b -> result) fed from latched operands.

Verification
REQ-029 SHALL cover: req0 ADD a=7 b=5, resp_ready=1 -> req0_ready at T, resp_valid at T+2, resp_result=12, resp_id=0.
REQ-030 SHALL cover: both valid after reset, req0 SUB 3-5, req1 XOR F0F0F0F0^0F0F0F0F -> req0 first result FFFFFFFE, then req1 result FFFFFFFF.
REQ-031 SHALL cover: DIV 100/0 -> result FFFFFFFF; with ALU_ARBITER_DIV0_ERR_EN resp_err=1; DIV 100/7 -> 14, resp_err=0.
REQ-032 SHALL cover: SHL 1 by 31 -> 80000000; SHR FFFFFFFF by 32 -> 0; MUL 0x10000*0x10000 -> 0.
REQ-033 SHALL cover: resp_ready low 5 cycles with req1_valid high -> resp outputs stable, req1_ready stays 0 until response accepted.
REQ-034 SHALL cover: rst_n low during EXEC -> resp_valid never asserts, next request after release served by req0 on tie.
